// File: rtl/microwave_pkg.sv
// Shared state encodings for the microwave control blocks.
// IDLE: no time set | SET: time entered | RUN: heating | PAUSE: held | FINISH: alarm sounding
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_SET    = 3'b001,
        ST_RUN    = 3'b010,
        ST_PAUSE  = 3'b011,
        ST_FINISH = 3'b100
    } state_t;

endpackage

// File: rtl/microwave_tick_gen.sv
// One-second tick generator: counts enabled cycles and pulses tick on the
// last cycle of each second. The count holds while en is low, so a pause resumes mid-second.
module microwave_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == CNT_MAX) r_cnt <= '0;
            else                  r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-time controller: button pulses set a saturating time, which counts down
// at 1 Hz with pause/resume, then a done pulse and a timed alarm.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TIME_W   = 14,
    parameter int STEP     = 30,
    parameter int MAX_TIME = 5970,
    parameter int ALARM_S  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btnU,
    input  logic              btnD,
    input  logic              btnC,
    input  logic              btnL,
    output logic [TIME_W-1:0] run_time,
    output logic [2:0]        state,
    output logic              heater_en,
    output logic              done,
    output logic              alarm
);

    localparam logic [TIME_W:0]   STEP_X     = (TIME_W + 1)'(STEP);
    localparam logic [TIME_W:0]   MAX_X      = (TIME_W + 1)'(MAX_TIME);
    localparam logic [TIME_W-1:0] STEP_T     = TIME_W'(STEP);
    localparam logic [TIME_W-1:0] MAX_T      = TIME_W'(MAX_TIME);
    localparam int                ALARM_W    = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_S - 1);

    state_t              r_state;
    logic [TIME_W-1:0]   r_run_time;
    logic                r_heater;
    logic                r_done;
    logic                r_alarm;
    logic [ALARM_W-1:0]  r_alarm_cnt;

    logic                w_tick;
    logic                w_tick_en;
    logic                w_tick_clr;
    logic [TIME_W:0]     w_sum;
    logic [TIME_W-1:0]   w_add;
    logic [TIME_W-1:0]   w_add_dec;
    logic [TIME_W-1:0]   w_sub;
    logic [TIME_W-1:0]   w_dec;
    logic                w_last;
    logic                w_any_btn;

    assign w_tick_en  = (r_state == ST_RUN) || (r_state == ST_FINISH);
    assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_SET);

    microwave_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick_en),
        .clr   (w_tick_clr),
        .tick  (w_tick)
    );

    // One extra bit so the add can be clamped before it could wrap.
    assign w_sum     = {1'b0, r_run_time} + STEP_X;
    assign w_add     = (w_sum > MAX_X) ? MAX_T : w_sum[TIME_W-1:0];
    assign w_add_dec = w_add - 1'b1;
    assign w_sub     = (r_run_time > STEP_T) ? (r_run_time - STEP_T) : '0;
    assign w_dec     = r_run_time - 1'b1;
    assign w_last    = (r_run_time <= TIME_W'(1));
    assign w_any_btn = btnU || btnD || btnC || btnL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_run_time  <= '0;
            r_heater    <= 1'b0;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_run_time <= '0;
                    if (btnU && !btnC && !btnL) begin
                        r_state    <= ST_SET;
                        r_run_time <= STEP_T;
                    end
                end
                ST_SET, ST_PAUSE: begin
                    if (btnL) begin
                        r_state    <= ST_IDLE;
                        r_run_time <= '0;
                    end else if (btnC) begin
                        r_state  <= ST_RUN;
                        r_heater <= 1'b1;
                    end else if (btnU) begin
                        r_run_time <= w_add;
                    end else if (btnD) begin
                        r_run_time <= w_sub;
                        if (w_sub == '0) r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (btnL) begin
                        r_state    <= ST_IDLE;
                        r_run_time <= '0;
                        r_heater   <= 1'b0;
                    end else if (btnU && !btnC) begin
                        r_run_time <= w_tick ? w_add_dec : w_add;
                    end else if (w_tick && w_last) begin
                        // Reaching zero beats a coincident pause request.
                        r_state     <= ST_FINISH;
                        r_run_time  <= '0;
                        r_heater    <= 1'b0;
                        r_alarm     <= 1'b1;
                        r_done      <= 1'b1;
                        r_alarm_cnt <= '0;
                    end else begin
                        if (w_tick) r_run_time <= w_dec;
                        if (btnC) begin
                            r_state  <= ST_PAUSE;
                            r_heater <= 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    if (w_any_btn) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end else if (w_tick) begin
                        if (r_alarm_cnt == ALARM_LAST) begin
                            r_state <= ST_IDLE;
                            r_alarm <= 1'b0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_run_time <= '0;
                    r_heater   <= 1'b0;
                    r_alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign run_time  = r_run_time;
    assign state     = r_state;
    assign heater_en = r_heater;
    assign done      = r_done;
    assign alarm     = r_alarm;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: vector table, hand-written corner sequences,
// and random button traffic compared against a seconds-level reference model.
module tb_microwave_timer_ctrl;

    localparam int CLK_HZ   = 10;
    localparam int TIME_W   = 14;
    localparam int STEP     = 30;
    localparam int MAX_TIME = 5970;
    localparam int ALARM_S  = 3;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_FIN   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              btnU, btnD, btnC, btnL;
    logic [TIME_W-1:0] run_time;
    logic [2:0]        state;
    logic              heater_en, done, alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: seconds remaining, mode, and cycles counted in the current second.
    int m_rt, m_st, m_elapsed, m_alarm_secs;
    bit m_done;

    typedef struct {
        logic u, d, c, l;
        int   rt;
        int   st;
    } vec_t;

    vec_t vecs[16];

    microwave_timer_ctrl #(
        .CLK_HZ(CLK_HZ), .TIME_W(TIME_W), .STEP(STEP),
        .MAX_TIME(MAX_TIME), .ALARM_S(ALARM_S)
    ) dut (
        .clk(clk), .reset(reset),
        .btnU(btnU), .btnD(btnD), .btnC(btnC), .btnL(btnL),
        .run_time(run_time), .state(state),
        .heater_en(heater_en), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_run_time", run_time, m_rt);
        check("model_state", state, m_st);
        check("model_heater_en", heater_en, m_st == S_RUN);
        check("model_alarm", alarm, m_st == S_FIN);
        check("model_done", done, m_done);
    endtask

    task automatic model_reset();
        m_rt = 0; m_st = S_IDLE; m_elapsed = 0; m_alarm_secs = 0; m_done = 0;
    endtask

    function automatic int add_time(input int t);
        return (t + STEP > MAX_TIME) ? MAX_TIME : t + STEP;
    endfunction

    task automatic model_step(input bit u, input bit d, input bit c, input bit l);
        int  act;
        bit  tick;
        int  nrt;
        act  = l ? 4 : c ? 3 : u ? 2 : d ? 1 : 0;
        tick = (m_st == S_RUN || m_st == S_FIN) && (m_elapsed % CLK_HZ == CLK_HZ - 1);
        if (m_st == S_RUN || m_st == S_FIN) m_elapsed++;
        m_done = 0;
        case (m_st)
            S_IDLE: if (act == 2) begin m_st = S_SET; m_rt = STEP; end
            S_SET, S_PAUSE: begin
                if (act == 4) m_st = S_IDLE;
                else if (act == 3) begin
                    if (m_st == S_SET) m_elapsed = 0;
                    m_st = S_RUN;
                end else if (act == 2) m_rt = add_time(m_rt);
                else if (act == 1) begin
                    m_rt = (m_rt > STEP) ? m_rt - STEP : 0;
                    if (m_rt == 0) m_st = S_IDLE;
                end
            end
            S_RUN: begin
                if (act == 4) m_st = S_IDLE;
                else begin
                    nrt = m_rt;
                    if (act == 2) nrt = add_time(nrt);
                    if (tick) nrt = nrt - 1;
                    if (nrt <= 0) begin
                        nrt = 0; m_st = S_FIN; m_done = 1;
                        m_elapsed = 0; m_alarm_secs = 0;
                    end else if (act == 3) m_st = S_PAUSE;
                    m_rt = nrt;
                end
            end
            S_FIN: begin
                if (act != 0) m_st = S_IDLE;
                else if (tick) begin
                    m_alarm_secs++;
                    if (m_alarm_secs == ALARM_S) m_st = S_IDLE;
                end
            end
            default: m_st = S_IDLE;
        endcase
        if (m_st == S_IDLE) begin m_rt = 0; m_elapsed = 0; end
        if (m_st == S_SET) m_elapsed = 0;
    endtask

    task automatic cycle(input bit u, input bit d, input bit c, input bit l);
        @(negedge clk);
        btnU = u; btnD = d; btnC = c; btnL = l;
        @(posedge clk);
        model_step(u, d, c, l);
        #1;
        btnU = 0; btnD = 0; btnC = 0; btnL = 0;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_rt"}, run_time, 0);
        check({tag, "_state"}, state, S_IDLE);
        check({tag, "_heater"}, heater_en, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_alarm"}, alarm, 0);
        @(posedge clk);
        #1 check({tag, "_done_held"}, done, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [3:0] b;
        reset = 1'b1;
        btnU = 0; btnD = 0; btnC = 0; btnL = 0;
        model_reset();

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 30, S_SET};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 60, S_SET};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 90, S_SET};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 60, S_SET};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30, S_SET};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  S_IDLE};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  S_IDLE};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  S_IDLE};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  S_IDLE};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 30, S_SET};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 0,  S_IDLE};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 30, S_SET};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 30, S_RUN};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 60, S_RUN};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 60, S_RUN};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  S_IDLE};

        #12;
        check("reset_rt", run_time, 0);
        check("reset_state", state, S_IDLE);
        check("reset_heater", heater_en, 0);
        check("reset_done", done, 0);
        check("reset_alarm", alarm, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].u, vecs[i].d, vecs[i].c, vecs[i].l);
            check($sformatf("vec%0d_rt", i), run_time, vecs[i].rt);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
        end

        // Saturation
        for (int i = 0; i < 200; i++) cycle(1, 0, 0, 0);
        check("sat_rt", run_time, MAX_TIME);
        cycle(0, 0, 0, 1);
        check("sat_clear_rt", run_time, 0);
        check("sat_clear_state", state, S_IDLE);

        // Countdown and alarm
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("cd_heater", heater_en, 1);
        idle(9);
        check("cd_hold_rt", run_time, 30);
        idle(1);
        check("cd_first_dec", run_time, 29);
        idle(289);
        check("cd_last_rt", run_time, 1);
        check("cd_last_done", done, 0);
        idle(1);
        check("cd_fin_state", state, S_FIN);
        check("cd_fin_done", done, 1);
        check("cd_fin_alarm", alarm, 1);
        check("cd_fin_heater", heater_en, 0);
        idle(1);
        check("cd_done_once", done, 0);
        idle(28);
        check("cd_alarm_end", alarm, 1);
        idle(1);
        check("cd_alarm_off", alarm, 0);
        check("cd_back_idle", state, S_IDLE);

        // Pause mid-second, resume from the frozen count
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        idle(3);
        cycle(0, 0, 1, 0);
        check("pause_state", state, S_PAUSE);
        idle(50);
        check("pause_heater", heater_en, 0);
        check("pause_rt", run_time, 30);
        cycle(0, 0, 1, 0);
        check("resume_heater", heater_en, 1);
        idle(5);
        check("resume_hold_rt", run_time, 30);
        idle(1);
        check("resume_dec_rt", run_time, 29);
        cycle(0, 0, 0, 1);

        // Quick add and cancel on tick cycles
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        idle(299);
        check("qa_pre_rt", run_time, 1);
        cycle(1, 0, 0, 0);
        check("qa_rt", run_time, 30);
        check("qa_state", state, S_RUN);
        check("qa_done", done, 0);
        idle(9);
        cycle(0, 0, 0, 1);
        check("cancel_rt", run_time, 0);
        check("cancel_state", state, S_IDLE);

        // Asynchronous reset mid-RUN and mid-FINISH
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        idle(15);
        async_reset_check("rst_run");
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        idle(300);
        check("rst_pre_fin", state, S_FIN);
        idle(5);
        async_reset_check("rst_fin");

        // Random button traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            b = {r < 10, (r >= 10 && r < 16), (r >= 16 && r < 20), r == 20};
            if (r >= 196) b = 4'($urandom_range(0, 15));
            cycle(b[3], b[2], b[1], b[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
